wbus_transfer_scheduler: RTL
============================

Name: wbus_transfer_scheduler

Overview:
Sequences register-to-register transfers over the shared 8-bit W-bus. Arbitrates round-robin between N_SRC bus-driving registers (TMP, ACC, B, C, ...). Drives their tri-state output enables and the destination registers' load enables. Guarantees at most one driver on the bus per cycle and a load strobe only while the bus is stably driven.

Parameters:
N_SRC, 4, number of bus sources/requesters (2..8)
N_DST, 4, number of loadable destination registers (2..8)
DST_W, 2, width of each destination index field; must satisfy 2**DST_W >= N_DST

Ports:
inCLK  input  1  system clock, all state updates on posedge
inCLR_n  input  1  asynchronous active-low reset
inReq  input  N_SRC  per-source transfer request, level, held until ack
inDest  input  N_SRC*DST_W  destination index per source; field i = inDest[i*DST_W +: DST_W]
outEnableOut  output  N_SRC  one-hot-or-zero source output enable (to bufif1 enables)
outLoad  output  N_DST  one-hot-or-zero destination load enable
outAck  output  N_SRC  one-cycle completion pulse to granted source
outErr  output  1  one-cycle pulse: granted request had destination index >= N_DST
outBusy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, inCLR_n low): state IDLE; outEnableOut, outLoad, outAck = 0; outErr = 0; outBusy = 0; round-robin pointer = 0 (source 0 highest priority). All outputs registered.
- States: IDLE, DRIVE, LOAD, RELEASE.
- IDLE: if any inReq bit is set, grant the first set bit at or after pointer (wrapping modulo N_SRC). Latch the granted index and its inDest field. Go to DRIVE; set outEnableOut[grant] = 1. With no request, stay in IDLE with all outputs 0.
- Illegal destination: the latched destination is >= N_DST. Go directly to RELEASE. Pulse outErr and outAck[grant] for that RELEASE cycle. Never assert outEnableOut or outLoad.
- DRIVE (1 cycle, bus settle): outEnableOut[grant] = 1, outLoad = 0.
  - If inReq[grant] has dropped, abort: go to IDLE, clear enable, no ack, pointer unchanged.
  - Otherwise go to LOAD.
- LOAD (1 cycle): outEnableOut[grant] = 1 and outLoad[dest] = 1. The destination captures on the posedge ending LOAD. The transfer is committed; a request drop here is ignored. Go to RELEASE.
- RELEASE (1 cycle, dead cycle): outEnableOut = 0, outLoad = 0, outAck[grant] = 1. Pointer = (grant+1) mod N_SRC. Go to IDLE.
- Latency from req sampled high in IDLE: enable is visible 1 cycle later, load 2 cycles later, ack 3 cycles later. Minimum 4 cycles per transfer.
- The source must drop or re-assert inReq after seeing ack; if still high in IDLE, it is treated as a new request.
- Requests arriving while busy wait; inReq and inDest are sampled only in IDLE (dest latched at grant).
- Invariants: popcount(outEnableOut) <= 1 and popcount(outLoad) <= 1 every cycle. outLoad is nonzero only when outEnableOut is nonzero.
- Reset mid-transfer: all enables and loads drop asynchronously; no ack is issued.

Optional Feature:
Macro WBUS_DEADCYCLE_EN.
- Defined: RELEASE state present as above; bus has one undriven cycle between transfers.
- Undefined: LOAD goes directly to IDLE.
  - Ack and pointer update happen in the first IDLE cycle.
  - A new grant is evaluated in that same IDLE cycle, giving 3 cycles per transfer.
  - The error path pulses outErr/outAck from IDLE without entering RELEASE.
  - One-driver invariant still holds because enables are registered from a single state.

Test Plan:
- Reset then idle, inReq=0 for 10 cycles -> all outputs 0, outBusy 0; assert inCLR_n low mid-LOAD -> outEnableOut/outLoad 0 immediately, no ack.
- Single transfer: inReq=4'b0010, dest field1=3.
  - outEnableOut=0010 in cycles 1-2; outLoad=1000 in cycle 2 only.
  - outAck=0010 in cycle 3; the mFlipFlop-based destination holds the driven byte 0xA5.
- Round-robin: inReq=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0 and never two enable bits set.
- Abort: grant source 2, drop inReq[2] during DRIVE -> IDLE next cycle, no outLoad, no outAck, source 2 keeps priority.
- Illegal destination with N_DST=3, dest=3 -> outErr and outAck pulse together, outLoad never asserted.
- WBUS_DEADCYCLE_EN undefined, back-to-back requests from sources 0 and 1 -> transfers every 3 cycles, enables never overlap.

Source files
------------

// File: rtl/wbus_transfer_scheduler.sv
// -----------------------------------------------------------------------------
// wbus_transfer_scheduler
//
// Sequences register-to-register transfers over the shared 8-bit W-bus.
// Sources are granted round-robin. The grant drives exactly one source output
// enable and then exactly one destination load enable. The load is asserted
// only after the bus has had one full cycle to settle.
//
// Ports
//   inCLK         system clock; all state updates on posedge
//   inCLR_n       asynchronous active-low reset
//   inReq         per-source request (level, held until ack)
//   inDest        per-source destination index; field i = inDest[i*DST_W +: DST_W]
//   outEnableOut  one-hot-or-zero source output enable (to the bufif1 enables)
//   outLoad       one-hot-or-zero destination load enable
//   outAck        one-cycle completion pulse to the granted source
//   outErr        one-cycle pulse: granted request named a destination >= N_DST
//   outBusy       high in any state other than IDLE
//
// Build option
//   WBUS_DEADCYCLE_EN  defined   : LOAD -> RELEASE -> IDLE. The bus is left
//                                  undriven for one cycle between transfers,
//                                  so each transfer takes 4 cycles.
//                      undefined : LOAD -> IDLE. Ack and the pointer update
//                                  appear in that IDLE cycle, and the next
//                                  grant is taken in the same cycle, so each
//                                  transfer takes 3 cycles.
// -----------------------------------------------------------------------------
module wbus_transfer_scheduler #(
    parameter int N_SRC = 4,
    parameter int N_DST = 4,
    parameter int DST_W = 2
) (
    input  logic                   inCLK,
    input  logic                   inCLR_n,
    input  logic [N_SRC-1:0]       inReq,
    input  logic [N_SRC*DST_W-1:0] inDest,
    output logic [N_SRC-1:0]       outEnableOut,
    output logic [N_DST-1:0]       outLoad,
    output logic [N_SRC-1:0]       outAck,
    output logic                   outErr,
    output logic                   outBusy
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_LOAD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // State that follows a finished (or rejected) transfer.
`ifdef WBUS_DEADCYCLE_EN
    localparam state_t S_END = S_RELEASE;
`else
    localparam state_t S_END = S_IDLE;
`endif

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [DST_W-1:0]   r_dest;
    logic [N_SRC-1:0]   r_enable;
    logic [N_DST-1:0]   r_load;
    logic [N_SRC-1:0]   r_ack;
    logic               r_err;
    logic               r_busy;

    state_t             w_state_nxt;
    logic               w_found;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [DST_W-1:0]   w_req_dest;
    logic               w_dest_ok;
    logic               w_req_held;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [N_SRC-1:0]   w_enable_nxt;
    logic [N_DST-1:0]   w_load_nxt;
    logic [N_SRC-1:0]   w_ack_nxt;
    logic               w_err_nxt;
    logic               w_busy_nxt;

    // One-hot selects are built by comparison so that an index wider than the
    // vector can never produce an out-of-range select.
    function automatic logic [N_SRC-1:0] f_src_sel(input logic [IDX_W-1:0] idx);
        f_src_sel = '0;
        for (int i = 0; i < N_SRC; i++)
            if (int'(idx) == i) f_src_sel[i] = 1'b1;
    endfunction

    function automatic logic [N_DST-1:0] f_dst_sel(input logic [DST_W-1:0] idx);
        f_dst_sel = '0;
        for (int d = 0; d < N_DST; d++)
            if (int'(idx) == d) f_dst_sel[d] = 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] f_ptr_inc(input logic [IDX_W-1:0] idx);
        f_ptr_inc = (int'(idx) == N_SRC - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    // Round-robin search: first requesting source at or after r_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        w_found     = 1'b0;
        w_grant_idx = r_ptr;
        for (int k = 0; k < N_SRC; k++) begin
            if (!w_found && |(inReq & f_src_sel(IDX_W'((int'(r_ptr) + k) % N_SRC)))) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'((int'(r_ptr) + k) % N_SRC);
            end
        end
        w_req_dest = '0;
        for (int i = 0; i < N_SRC; i++)
            if (int'(w_grant_idx) == i) w_req_dest = inDest[i*DST_W +: DST_W];
    end

    assign w_dest_ok  = (int'(w_req_dest) < N_DST);
    assign w_req_held = |(inReq & f_src_sel(r_grant));

    // State register. The outputs are registered here as well, so every output
    // is a flop and the enables for one cycle come from a single state decision.
    always_ff @(posedge inCLK or negedge inCLR_n) begin
        if (!inCLR_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_dest   <= '0;
            r_enable <= '0;
            r_load   <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, whatever order the statements appear in.
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_enable <= w_enable_nxt;
            r_load   <= w_load_nxt;
            r_ack    <= w_ack_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            // Request and destination are captured only at the grant.
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_grant_idx;
                r_dest  <= w_req_dest;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found)
                    w_state_nxt = w_dest_ok ? S_DRIVE : S_END;
            end
            // A request dropped during the settle cycle aborts the transfer.
            S_DRIVE:   w_state_nxt = w_req_held ? S_LOAD : S_IDLE;
            // The transfer is committed once LOAD is entered.
            S_LOAD:    w_state_nxt = S_END;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: values the outputs take for the cycle after this edge.
    always_comb begin
        w_enable_nxt = '0;
        w_load_nxt   = '0;
        w_ack_nxt    = '0;
        w_err_nxt    = 1'b0;
        w_ptr_nxt    = r_ptr;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (w_dest_ok) begin
                        w_enable_nxt = f_src_sel(w_grant_idx);
                    end else begin
                        // Rejected grant: complete immediately and never drive.
                        w_ack_nxt = f_src_sel(w_grant_idx);
                        w_err_nxt = 1'b1;
                        w_ptr_nxt = f_ptr_inc(w_grant_idx);
                    end
                end
            end
            S_DRIVE: begin
                // On abort, enable drops and the pointer stays on this source.
                if (w_req_held) begin
                    w_enable_nxt = f_src_sel(r_grant);
                    w_load_nxt   = f_dst_sel(r_dest);
                end
            end
            S_LOAD: begin
                w_ack_nxt = f_src_sel(r_grant);
                w_ptr_nxt = f_ptr_inc(r_grant);
            end
            default: begin
            end
        endcase
    end

    assign outEnableOut = r_enable;
    assign outLoad      = r_load;
    assign outAck       = r_ack;
    assign outErr       = r_err;
    assign outBusy      = r_busy;

endmodule
